// File: rtl/regfile_writeback_queue_if.sv
// Write-back request channel between the datapath (master) and the
// register-file write-back queue (slave).
interface regfile_writeback_queue_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
);
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_W-1:0]  wb_sel;
  logic [WORD_W-1:0] wb_dat;

  modport master (output wb_valid, output wb_sel, output wb_dat, input wb_ready);
  modport slave  (input wb_valid, input wb_sel, input wb_dat, output wb_ready);
endinterface

// File: rtl/regfile_writeback_queue.sv
// Buffers write-back requests and drains them into the register file write port,
// stalling while decode reads and forwarding the youngest queued value per register.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  regfile_writeback_queue_if.slave   wb,
  input  logic                       rd_busy,
  input  logic                       flush,
  output logic                       WEN,
  output logic [REG_W-1:0]           wsel,
  output logic [WORD_W-1:0]          wdat,
  input  logic [REG_W-1:0]           q_sel,
  output logic                       q_pending,
  output logic [WORD_W-1:0]          q_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [REG_W-1:0]  sel_q [DEPTH];
  logic [REG_W-1:0]  sel_d [DEPTH];
  logic [WORD_W-1:0] dat_q [DEPTH];
  logic [WORD_W-1:0] dat_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full, ready, push, pop;
  logic [PTR_W-1:0]  fwd_idx;
  logic              fwd_hit;
  logic [WORD_W-1:0] fwd_dat;

  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    ready = !full && !flush;
    // A select of 0 targets the hard-wired zero register: accept but drop it.
    push  = wb.wb_valid && ready && (wb.wb_sel != '0);
    // A reset cycle must not leak a write into the register file.
    pop   = (count_q != '0) && !rd_busy && !flush && !RST;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    sel_d   = sel_q;
    dat_d   = dat_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        sel_d[tail_q] = wb.wb_sel;
        dat_d[tail_q] = wb.wb_dat;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    fwd_idx = '0;
    fwd_hit = 1'b0;
    fwd_dat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (sel_q[fwd_idx] == q_sel) && (q_sel != '0)) begin
        fwd_hit = 1'b1;
        fwd_dat = dat_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge CLK) begin
      if (RST) begin
        sel_q[gi] <= '0;
        dat_q[gi] <= '0;
      end else begin
        sel_q[gi] <= sel_d[gi];
        dat_q[gi] <= dat_d[gi];
      end
    end
  end

  assign wb.wb_ready = ready;
  assign WEN         = pop;
  assign wsel        = pop ? sel_q[head_q] : '0;
  assign wdat        = pop ? dat_q[head_q] : '0;
  assign q_pending   = fwd_hit;
  assign q_dat       = fwd_dat;
  assign count       = count_q;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench: queue-based reference model checked every cycle plus
// hand-computed literal expectations for each scenario.
module tb_regfile_writeback_queue;
  localparam int DEPTH  = 4;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  logic              CLK = 1'b0;
  logic              RST;
  logic              rd_busy, flush;
  logic              WEN;
  logic [REG_W-1:0]  wsel, q_sel;
  logic [WORD_W-1:0] wdat, q_dat;
  logic              q_pending;
  logic [2:0]        count;

  regfile_writeback_queue_if #(.WORD_W(WORD_W), .REG_W(REG_W)) wb_if();

  regfile_writeback_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .RST(RST), .wb(wb_if), .rd_busy(rd_busy), .flush(flush),
    .WEN(WEN), .wsel(wsel), .wdat(wdat), .q_sel(q_sel),
    .q_pending(q_pending), .q_dat(q_dat), .count(count)
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit started = 1'b0;
  logic [WORD_W-1:0] rf_obs [32];

  typedef struct { logic [REG_W-1:0] sel; logic [WORD_W-1:0] dat; } ent_t;
  ent_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a plain queue of accepted requests, updated at each clock edge.
  always @(posedge CLK) begin
    bit do_push, do_pop;
    do_push = wb_if.wb_valid && (mq.size() < DEPTH) && !flush && (wb_if.wb_sel != 0);
    do_pop  = (mq.size() != 0) && !rd_busy && !flush && !RST;
    if (RST || flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{wb_if.wb_sel, wb_if.wb_dat});
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      logic e_wen, e_pend;
      logic [REG_W-1:0] e_sel;
      logic [WORD_W-1:0] e_dat, e_qd;
      e_wen = (mq.size() != 0) && !rd_busy && !flush && !RST;
      e_sel = e_wen ? mq[0].sel : '0;
      e_dat = e_wen ? mq[0].dat : '0;
      e_pend = 1'b0;
      e_qd = '0;
      foreach (mq[i]) if (q_sel != 0 && mq[i].sel == q_sel) begin
        e_pend = 1'b1;
        e_qd = mq[i].dat;
      end
      chk("m_ready", 32'(wb_if.wb_ready), 32'((mq.size() < DEPTH) && !flush));
      chk("m_wen", 32'(WEN), 32'(e_wen));
      chk("m_wsel", 32'(wsel), 32'(e_sel));
      chk("m_wdat", wdat, e_dat);
      chk("m_qpend", 32'(q_pending), 32'(e_pend));
      chk("m_qdat", q_dat, e_qd);
      chk("m_count", 32'(count), mq.size());
      if (WEN) rf_obs[wsel] = wdat;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [REG_W-1:0] s, input logic [WORD_W-1:0] d);
    wb_if.wb_valid = 1'b1;
    wb_if.wb_sel = s;
    wb_if.wb_dat = d;
    cyc();
    wb_if.wb_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; rd_busy = 1'b0; flush = 1'b0; q_sel = '0;
    wb_if.wb_valid = 1'b0; wb_if.wb_sel = '0; wb_if.wb_dat = '0;
    foreach (rf_obs[i]) rf_obs[i] = '0;
    repeat (2) cyc();
    started = 1'b1;
    RST = 1'b0;

    // 1: single write
    @(negedge CLK);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(wb_if.wb_ready), 1);
    chk("rst_wen", 32'(WEN), 0);
    cyc();
    push(5'd3, 32'hDEADBEEF);
    @(negedge CLK);
    chk("t1_wen", 32'(WEN), 1);
    chk("t1_wsel", 32'(wsel), 3);
    chk("t1_wdat", wdat, 32'hDEADBEEF);
    cyc();
    @(negedge CLK);
    chk("t1_count", 32'(count), 0);
    cyc();

    // 2: fill while stalled, then drain in order
    rd_busy = 1'b1;
    for (int i = 1; i <= 4; i++) push(REG_W'(i), 32'h100 + i);
    @(negedge CLK);
    chk("t2_count", 32'(count), 4);
    chk("t2_ready", 32'(wb_if.wb_ready), 0);
    cyc();
    rd_busy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      chk("t2_wen", 32'(WEN), 1);
      chk("t2_wsel", 32'(wsel), i);
      cyc();
    end
    @(negedge CLK);
    chk("t2_empty", 32'(count), 0);
    cyc();

    // 3: writes to register 0 are dropped
    wb_if.wb_valid = 1'b1; wb_if.wb_sel = '0; wb_if.wb_dat = 32'h1234;
    @(negedge CLK);
    chk("t3_ready", 32'(wb_if.wb_ready), 1);
    cyc();
    wb_if.wb_valid = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("t3_wen", 32'(WEN), 0);
      chk("t3_count", 32'(count), 0);
      cyc();
    end

    // 4: forwarding picks the youngest duplicate
    rd_busy = 1'b1;
    push(5'd5, 32'hA);
    push(5'd5, 32'hB);
    q_sel = 5'd5;
    @(negedge CLK);
    chk("t4_qpend", 32'(q_pending), 1);
    chk("t4_qdat", q_dat, 32'hB);
    cyc();
    rd_busy = 1'b0;
    repeat (3) cyc();
    chk("t4_rf5", rf_obs[5], 32'hB);

    // 5: flush a full queue
    rd_busy = 1'b1;
    for (int i = 6; i <= 9; i++) push(REG_W'(i), 32'h200 + i);
    q_sel = 5'd6;
    flush = 1'b1;
    @(negedge CLK);
    chk("t5_wen", 32'(WEN), 0);
    chk("t5_ready", 32'(wb_if.wb_ready), 0);
    chk("t5_qpend_pre", 32'(q_pending), 1);
    cyc();
    flush = 1'b0; rd_busy = 1'b0;
    @(negedge CLK);
    chk("t5_count", 32'(count), 0);
    chk("t5_ready1", 32'(wb_if.wb_ready), 1);
    chk("t5_qpend", 32'(q_pending), 0);
    cyc();

    // 6: streaming, then reset mid-stream
    q_sel = 5'd12;
    wb_if.wb_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wb_if.wb_sel = REG_W'(10 + i);
      wb_if.wb_dat = 32'h300 + i;
      @(negedge CLK);
      if (i > 0) begin
        chk("t6_count", 32'(count), 1);
        chk("t6_wen", 32'(WEN), 1);
        chk("t6_wsel", 32'(wsel), 10 + i - 1);
      end
      cyc();
    end
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_rst_wen", 32'(WEN), 0);
    cyc();
    RST = 1'b0;
    wb_if.wb_valid = 1'b0;
    q_sel = 5'd15;
    @(negedge CLK);
    chk("t6_r_count", 32'(count), 0);
    chk("t6_r_ready", 32'(wb_if.wb_ready), 1);
    chk("t6_r_wen", 32'(WEN), 0);
    chk("t6_r_wsel", 32'(wsel), 0);
    chk("t6_r_wdat", wdat, 0);
    chk("t6_r_qpend", 32'(q_pending), 0);
    chk("t6_r_qdat", q_dat, 0);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
